// File: rtl/obs_field.sv
// Purpose : N_OBS-slot falling-obstacle engine; spawns, moves, hit/miss-tests obstacles once per frame.
// Latency : obs_on/flash_on/active_cnt combinational; hit_mask/miss_mask/shot_consume one clk after the frame tick.
// Backpress: none; game_stop synchronously clears every slot, the spawn timer and the pulses.
// Ports   : clk, rst (async, active-high); x,y pixel scan position; game_stop, level, shot_valid,
//           shot_x_l, shot_y_t in; obs_on, flash_on, hit_mask, miss_mask, shot_consume, active_cnt out.
module obs_field #(
    parameter int         N_OBS        = 4,
    parameter int         OBS_SIZE     = 20,
    parameter int         OBS_V_BASE   = 2,
    parameter int         SPAWN_GAP    = 30,
    parameter int         FLASH_FRAMES = 8,
    parameter int         BOTTOM_Y     = 470,
    parameter int         SHOT_SIZE    = 6,
    parameter int         MAX_X        = 640,
    parameter int         MAX_Y        = 480,
    parameter logic [9:0] LFSR_SEED    = 10'h001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       x,
    input  logic [9:0]       y,
    input  logic             game_stop,
    input  logic [1:0]       level,
    input  logic             shot_valid,
    input  logic [9:0]       shot_x_l,
    input  logic [9:0]       shot_y_t,
    output logic             obs_on,
    output logic             flash_on,
    output logic [N_OBS-1:0] hit_mask,
    output logic [N_OBS-1:0] miss_mask,
    output logic             shot_consume,
    output logic [2:0]       active_cnt
);

    // Counter widths guarded so a gap/flash length of 1 still yields a legal 1-bit counter.
    localparam int TW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FALL = 2'd1, S_FLASH = 2'd2} slot_st_t;

    slot_st_t         st     [N_OBS];
    slot_st_t         st_n   [N_OBS];
    logic [9:0]       ox     [N_OBS];
    logic [9:0]       ox_n   [N_OBS];
    logic [9:0]       oy     [N_OBS];
    logic [9:0]       oy_n   [N_OBS];
    logic [FW-1:0]    fcnt   [N_OBS];
    logic [FW-1:0]    fcnt_n [N_OBS];
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_n;
    logic [9:0]       lfsr;
    logic [9:0]       spawn_x;
    logic [N_OBS-1:0] hit_n;
    logic [N_OBS-1:0] miss_n;
    logic             refr_tick;
    logic [10:0]      speed;
    logic             spawn_done;

    assign refr_tick = (x == 10'(MAX_X - 1)) && (y == 10'(MAX_Y - 1));
    assign speed     = 11'(OBS_V_BASE) + {9'd0, level};
    // Fold LFSR values past the right edge back into the visible span.
    assign spawn_x   = (lfsr > 10'(MAX_X - OBS_SIZE)) ? lfsr - 10'(MAX_X - OBS_SIZE) : lfsr;

    // Shot square (top-left a) overlaps obstacle square (top-left b); 11-bit math avoids wrap.
    function automatic logic overlaps(input logic [9:0] ax, input logic [9:0] ay,
                                      input logic [9:0] bx, input logic [9:0] by);
        return ({1'b0, ax} <= {1'b0, bx} + 11'(OBS_SIZE - 1)) &&
               ({1'b0, bx} <= {1'b0, ax} + 11'(SHOT_SIZE - 1)) &&
               ({1'b0, ay} <= {1'b0, by} + 11'(OBS_SIZE - 1)) &&
               ({1'b0, by} <= {1'b0, ay} + 11'(SHOT_SIZE - 1));
    endfunction

    function automatic logic covers(input logic [9:0] px, input logic [9:0] py,
                                    input logic [9:0] bx, input logic [9:0] by);
        return (px >= bx) && ({1'b0, px} < {1'b0, bx} + 11'(OBS_SIZE)) &&
               (py >= by) && ({1'b0, py} < {1'b0, by} + 11'(OBS_SIZE));
    endfunction

    // Free-running LFSR; game_stop leaves it alone so successive games differ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[9] ^ lfsr[5] ^ lfsr[0], lfsr[9:1]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_OBS; i++) begin
                st[i]   <= S_IDLE;
                ox[i]   <= '0;
                oy[i]   <= '0;
                fcnt[i] <= '0;
            end
            timer        <= '0;
            hit_mask     <= '0;
            miss_mask    <= '0;
            shot_consume <= 1'b0;
        end else begin
            for (int i = 0; i < N_OBS; i++) begin
                st[i]   <= st_n[i];
                ox[i]   <= ox_n[i];
                oy[i]   <= oy_n[i];
                fcnt[i] <= fcnt_n[i];
            end
            timer        <= timer_n;
            hit_mask     <= hit_n;
            miss_mask    <= miss_n;
            shot_consume <= |hit_n;
        end
    end

    // Next-state logic. Every test uses pre-tick positions; spawning looks at pre-tick
    // IDLE slots, so a slot freed on this tick is not reused until a later spawn.
    always_comb begin
        for (int i = 0; i < N_OBS; i++) begin
            st_n[i]   = st[i];
            ox_n[i]   = ox[i];
            oy_n[i]   = oy[i];
            fcnt_n[i] = fcnt[i];
        end
        timer_n    = timer;
        hit_n      = '0;
        miss_n     = '0;
        spawn_done = 1'b0;
        if (game_stop) begin
            for (int i = 0; i < N_OBS; i++) st_n[i] = S_IDLE;
            timer_n = '0;
        end else if (refr_tick) begin
            for (int i = 0; i < N_OBS; i++) begin
                case (st[i])
                    S_FALL: begin
                        if (shot_valid && overlaps(shot_x_l, shot_y_t, ox[i], oy[i])) begin
                            st_n[i]   = S_FLASH;
                            fcnt_n[i] = '0;
                            hit_n[i]  = 1'b1;
                        end else if ({1'b0, oy[i]} + speed + 11'(OBS_SIZE - 1) >= 11'(BOTTOM_Y)) begin
                            st_n[i]   = S_IDLE;
                            miss_n[i] = 1'b1;
                        end else begin
                            oy_n[i] = oy[i] + speed[9:0];
                        end
                    end
                    S_FLASH: begin
                        if (fcnt[i] == FW'(FLASH_FRAMES - 1)) st_n[i] = S_IDLE;
                        else                                  fcnt_n[i] = fcnt[i] + FW'(1);
                    end
                    default: ;
                endcase
            end
            if (timer == TW'(SPAWN_GAP - 1)) begin
                timer_n = '0;
                for (int i = 0; i < N_OBS; i++) begin
                    if (!spawn_done && st[i] == S_IDLE) begin
                        st_n[i]    = S_FALL;
                        ox_n[i]    = spawn_x;
                        oy_n[i]    = '0;
                        spawn_done = 1'b1;
                    end
                end
            end else begin
                timer_n = timer + TW'(1);
            end
        end
    end

    // Output logic: pixel flags and occupancy
    always_comb begin
        obs_on     = 1'b0;
        flash_on   = 1'b0;
        active_cnt = '0;
        for (int i = 0; i < N_OBS; i++) begin
            if (st[i] == S_FALL  && covers(x, y, ox[i], oy[i])) obs_on   = 1'b1;
            if (st[i] == S_FLASH && covers(x, y, ox[i], oy[i])) flash_on = 1'b1;
            active_cnt = active_cnt + {2'b0, (st[i] != S_IDLE)};
        end
    end

endmodule

// File: tb/tb_obs_field.sv
// Purpose : directed bench for obs_field: reset, spawn, fall/miss, speed, hit/flash, priority, abort, full field.
// Latency : frame ticks are forced by parking x,y on the last pixel for one clk; pulses sampled 1 ns after the edge.
// Backpress: n/a; expected pulses are queued at tick drive time and popped when the DUT pulses.
module tb_obs_field;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       game_stop, game_stop2;
    logic [1:0] level;
    logic       shot_valid;
    logic [9:0] shot_x_l, shot_y_t;

    logic       obs_on, flash_on, shot_consume;
    logic [3:0] hit_mask, miss_mask;
    logic [2:0] active_cnt;
    logic       obs_on2, flash_on2, shot_consume2;
    logic [3:0] hit_mask2, miss_mask2;
    logic [2:0] active_cnt2;

    always #5 clk = ~clk;

    obs_field dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .game_stop(game_stop), .level(level),
        .shot_valid(shot_valid), .shot_x_l(shot_x_l), .shot_y_t(shot_y_t),
        .obs_on(obs_on), .flash_on(flash_on), .hit_mask(hit_mask), .miss_mask(miss_mask),
        .shot_consume(shot_consume), .active_cnt(active_cnt)
    );

    // Second instance with a one-frame spawn gap to fill the field quickly; never shot at.
    obs_field #(.SPAWN_GAP(1)) dut2 (
        .clk(clk), .rst(rst), .x(x), .y(y), .game_stop(game_stop2), .level(level),
        .shot_valid(1'b0), .shot_x_l(10'd0), .shot_y_t(10'd0),
        .obs_on(obs_on2), .flash_on(flash_on2), .hit_mask(hit_mask2), .miss_mask(miss_mask2),
        .shot_consume(shot_consume2), .active_cnt(active_cnt2)
    );

    // Reference LFSR straight from the polynomial, used only to predict spawn columns.
    logic [9:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 10'h001;
        else     m_lfsr <= {m_lfsr[9] ^ m_lfsr[5] ^ m_lfsr[0], m_lfsr[9:1]};
    end

    function automatic logic [9:0] sx_of(input logic [9:0] r);
        return (r > 10'd620) ? r - 10'd620 : r;
    endfunction

    typedef struct packed {
        logic [3:0] hit;
        logic [3:0] miss;
        logic       cons;
    } pulse_t;

    pulse_t     exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    logic [9:0] last_sx;
    int         sx0, sx1, sx2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One frame tick; expected pulses go to the scoreboard before the edge.
    task automatic tick(input logic [3:0] eh, input logic [3:0] em);
        pulse_t e;
        e.hit  = eh;
        e.miss = em;
        e.cons = |eh;
        exp_q.push_back(e);
        last_sx = sx_of(m_lfsr);
        x = 10'd639;
        y = 10'd479;
        @(posedge clk); #1;
        x = 10'd0;
        y = 10'd200;
        e = exp_q.pop_front();
        chk("hit_mask", 32'(hit_mask), 32'(e.hit));
        chk("miss_mask", 32'(miss_mask), 32'(e.miss));
        chk("shot_consume", 32'(shot_consume), 32'(e.cons));
        @(posedge clk); #1;
        chk("pulse_clear", 32'({hit_mask, miss_mask, shot_consume}), 32'd0);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick(4'b0000, 4'b0000);
    endtask

    task automatic probe(input string tag, input int px, input int py,
                         input logic eo, input logic ef);
        x = 10'(px);
        y = 10'(py);
        #1;
        chk({tag, "_obs"}, 32'(obs_on), 32'(eo));
        chk({tag, "_flash"}, 32'(flash_on), 32'(ef));
        @(posedge clk); #1;
        x = 10'd0;
        y = 10'd200;
    endtask

    task automatic stop_pulse();
        game_stop = 1'b1;
        @(posedge clk); #1;
        game_stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; game_stop = 1'b1; game_stop2 = 1'b1; level = 2'd0;
        shot_valid = 1'b0; shot_x_l = 10'd0; shot_y_t = 10'd0; x = 10'd0; y = 10'd0;

        // Reset with the scan moving, including over the tick pixel.
        for (int i = 0; i < 4; i++) begin
            x = (i == 2) ? 10'd639 : 10'(i * 100);
            y = (i == 2) ? 10'd479 : 10'(i * 50);
            @(posedge clk); #1;
            chk("rst_outputs", 32'({obs_on, flash_on, hit_mask, miss_mask, shot_consume, active_cnt}), 32'd0);
            chk("rst_outputs2", 32'({obs_on2, flash_on2, hit_mask2, miss_mask2, shot_consume2, active_cnt2}), 32'd0);
        end
        x = 10'd0; y = 10'd200;
        rst = 1'b0; game_stop = 1'b0;

        // Spawn on the 30th tick.
        ticks(29);
        chk("pre_spawn_active", 32'(active_cnt), 32'd0);
        tick(4'b0000, 4'b0000);
        sx0 = int'(last_sx);
        chk("spawn_active", 32'(active_cnt), 32'd1);
        probe("spawn_tl", sx0, 0, 1'b1, 1'b0);
        probe("spawn_right_out", sx0 + 20, 0, 1'b0, 1'b0);
        probe("spawn_br", sx0 + 19, 19, 1'b1, 1'b0);
        probe("spawn_below_out", sx0, 20, 1'b0, 1'b0);

        // Fall at level 0 to y=450, then miss on the next tick.
        ticks(225);
        probe("fall_450", sx0, 450, 1'b1, 1'b0);
        probe("fall_449", sx0, 449, 1'b0, 1'b0);
        chk("field_full_active", 32'(active_cnt), 32'd4);
        tick(4'b0000, 4'b0001);
        chk("after_miss_active", 32'(active_cnt), 32'd3);
        probe("after_miss_gone", sx0, 450, 1'b0, 1'b0);

        // Abort mid-flight: field clears next cycle with no pulses.
        stop_pulse();
        chk("abort_active", 32'(active_cnt), 32'd0);
        chk("abort_pulses", 32'({hit_mask, miss_mask, shot_consume}), 32'd0);
        ticks(2);

        // Hit and flash at level 0.
        stop_pulse();
        ticks(29);
        tick(4'b0000, 4'b0000);
        sx2 = int'(last_sx);
        ticks(14);
        shot_valid = 1'b1; shot_x_l = 10'(sx2 + 5); shot_y_t = 10'd48;
        tick(4'b0000, 4'b0000);
        shot_y_t = 10'd40;
        tick(4'b0001, 4'b0000);
        shot_valid = 1'b0;
        probe("flash_tl", sx2, 30, 1'b0, 1'b1);
        probe("flash_br", sx2 + 19, 49, 1'b0, 1'b1);
        probe("flash_out", sx2 + 20, 30, 1'b0, 1'b0);
        for (int j = 1; j < 8; j++) begin
            tick(4'b0000, 4'b0000);
            probe("flash_hold", sx2, 30, 1'b0, 1'b1);
        end
        tick(4'b0000, 4'b0000);
        probe("flash_done", sx2, 30, 1'b0, 1'b0);
        chk("flash_done_active", 32'(active_cnt), 32'd0);

        // Level 3 speed, then hit and bottom on the same tick.
        stop_pulse();
        level = 2'd3;
        ticks(29);
        tick(4'b0000, 4'b0000);
        sx1 = int'(last_sx);
        tick(4'b0000, 4'b0000);
        probe("speed_y5", sx1, 5, 1'b1, 1'b0);
        probe("speed_y4", sx1, 4, 1'b0, 1'b0);
        ticks(89);
        probe("l3_y450", sx1, 450, 1'b1, 1'b0);
        shot_valid = 1'b1; shot_x_l = 10'(sx1 + 5); shot_y_t = 10'd452;
        tick(4'b0001, 4'b0000);
        shot_valid = 1'b0;
        probe("prio_flash", sx1, 450, 1'b0, 1'b1);
        chk("prio_active", 32'(active_cnt), 32'd4);

        // Full field on the gap-1 instance; the fifth spawn is dropped.
        game_stop = 1'b1;
        game_stop2 = 1'b0;
        level = 2'd0;
        @(posedge clk); #1;
        for (int k = 1; k <= 5; k++) begin
            tick(4'b0000, 4'b0000);
            chk("full_active2", 32'(active_cnt2), 32'((k < 4) ? k : 4));
        end
        chk("stopped_active", 32'(active_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
